// File: rtl/sample_feeder.sv
// sample_feeder: DEPTH x 16 sample FIFO feeding a downstream averager.
// Each sample goes out with a data_ready strobe. The averager must then
// acknowledge it with a busy pulse on modwait.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   wr_en        push wr_data this cycle (dropped when full)
//   wr_data      16-bit sample to enqueue
//   modwait      downstream busy indication
//   sample_data  sample presented downstream, held through the handshake
//   data_ready   strobe, high for STROBE_LEN cycles per sample
//   count        FIFO occupancy, 0..DEPTH
//   full/empty   registered occupancy flags
//   overrun      sticky: a push was dropped because the FIFO was full
//   hs_err       sticky: modwait did not rise within TIMEOUT cycles
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a queued sample and modwait low; pops on entry out
// STROBE    | data_ready driven high for STROBE_LEN cycles
// WAIT_BUSY | waiting up to TIMEOUT cycles for modwait to rise
// WAIT_DONE | downstream busy; waiting for modwait to fall

module sample_feeder #(
    parameter int DEPTH      = 8,
    parameter int STROBE_LEN = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    input  logic                   modwait,
    output logic [15:0]            sample_data,
    output logic                   data_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overrun,
    output logic                   hs_err
);

    localparam int AW      = $clog2(DEPTH);
    localparam int TMR_MAX = (STROBE_LEN > TIMEOUT) ? STROBE_LEN : TIMEOUT;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] STROBE_C = TW'(STROBE_LEN);
    // The timer terminates on zero, so TIMEOUT-1 gives exactly TIMEOUT waiting cycles.
    localparam logic [TW-1:0] TMO_C    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        STROBE    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tmr;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_nxt;
    logic          push;
    logic          pop;

    // Both decisions use registered flags. A push in the same cycle as a pop
    // from a full FIFO is therefore still dropped.
    assign push = wr_en && !full;
    assign pop  = (state == IDLE) && !empty && !modwait;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && full)
                overrun <= 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tmr         <= '0;
            sample_data <= '0;
            data_ready  <= 1'b0;
            hs_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        sample_data <= mem[rd_ptr];
                        tmr         <= STROBE_C;
                        state       <= STROBE;
                    end
                end
                STROBE: begin
                    // The pop cycle leaves data_ready low. The strobe then
                    // covers the next STROBE_LEN cycles.
                    if (tmr != '0) begin
                        data_ready <= 1'b1;
                        tmr        <= tmr - 1'b1;
                    end else begin
                        data_ready <= 1'b0;
                        tmr        <= TMO_C;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (modwait) begin
                        state <= WAIT_DONE;
                    end else if (tmr == '0) begin
                        hs_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!modwait)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder. Stimulus pushes expected samples and status checks
// into queues. One monitor process compares them against the DUT on falling
// edges and also emulates the downstream busy response.

module tb_sample_feeder;

    localparam int STROBE_LEN = 2;

    typedef struct {
        string       name;
        int          cnt;
        bit [3:0]    flags;   // {full, empty, overrun, hs_err}
        bit          chk_dr;
        bit          dr;
        bit          chk_sd;
        logic [15:0] sd;
        bit          chk_q;
        bit          to;
    } chk_t;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        modwait;
    logic [15:0] sample_data;
    logic        data_ready;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overrun;
    logic        hs_err;

    logic        mw_main;
    logic        mw_resp;
    logic        resp_en;

    logic [15:0] exp_q [$];
    chk_t        req_q [$];
    int          n_vec;
    int          n_err;

    assign modwait = mw_main | mw_resp;

    sample_feeder #(.DEPTH(8), .STROBE_LEN(STROBE_LEN), .TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .modwait     (modwait),
        .sample_data (sample_data),
        .data_ready  (data_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .hs_err      (hs_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string name, input int cnt, input bit [3:0] flags,
                             input bit chk_dr, input bit dr,
                             input bit chk_sd, input logic [15:0] sd);
        chk_t r;
        r.name = name; r.cnt = cnt; r.flags = flags;
        r.chk_dr = chk_dr; r.dr = dr; r.chk_sd = chk_sd; r.sd = sd;
        r.chk_q = 1'b0; r.to = 1'b0;
        req_q.push_back(r);
    endtask

    task automatic expect_drain(input string name);
        chk_t r;
        r.name = name; r.cnt = 0; r.flags = '0;
        r.chk_dr = 1'b0; r.dr = 1'b0; r.chk_sd = 1'b0; r.sd = '0;
        r.chk_q = 1'b1; r.to = 1'b0;
        req_q.push_back(r);
    endtask

    task automatic note_timeout(input string name);
        chk_t r;
        r.name = name; r.cnt = 0; r.flags = '0;
        r.chk_dr = 1'b0; r.dr = 1'b0; r.chk_sd = 1'b0; r.sd = '0;
        r.chk_q = 1'b0; r.to = 1'b1;
        req_q.push_back(r);
    endtask

    task automatic push(input logic [15:0] v, input bit accepted);
        wr_en   = 1'b1;
        wr_data = v;
        if (accepted)
            exp_q.push_back(v);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++)
            tick();
        repeat (10) tick();
    endtask

    // Returns once the responder has released modwait, which is the cycle the
    // FSM is back in IDLE, so the next edge is a pop edge.
    task automatic wait_release(output bit ok);
        int n;
        n = 0;
        while (!mw_resp && n < 50) begin tick(); n++; end
        while (mw_resp && n < 50) begin tick(); n++; end
        ok = (n < 50);
    endtask

    // Monitor and downstream responder.
    initial begin
        chk_t        r_mon;
        logic        prev_dr;
        int          hi_cnt;
        int          resp_cnt;
        logic [15:0] held;
        logic [15:0] e;
        n_vec = 0; n_err = 0;
        mw_resp = 1'b0; prev_dr = 1'b0; hi_cnt = 0; resp_cnt = 0; held = '0;
        forever begin
            @(negedge clk);
            while (req_q.size() != 0) begin
                r_mon = req_q.pop_front();
                n_vec++;
                if (r_mon.to) begin
                    n_err++;
                    $display("FAIL %s: handshake wait expired", r_mon.name);
                end else if (r_mon.chk_q) begin
                    if (exp_q.size() != 0) begin
                        n_err++;
                        $display("FAIL %s: %0d samples never emerged, required 0", r_mon.name, exp_q.size());
                    end
                end else begin
                    if (int'(count) != r_mon.cnt || {full, empty, overrun, hs_err} !== r_mon.flags) begin
                        n_err++;
                        $display("FAIL %s: count=%0d {full,empty,ovr,hs_err}=%b, required count=%0d flags=%b",
                                 r_mon.name, count, {full, empty, overrun, hs_err}, r_mon.cnt, r_mon.flags);
                    end
                    if (r_mon.chk_dr && data_ready !== r_mon.dr) begin
                        n_err++;
                        $display("FAIL %s_dr: data_ready=%b, required %b", r_mon.name, data_ready, r_mon.dr);
                    end
                    if (r_mon.chk_sd && sample_data !== r_mon.sd) begin
                        n_err++;
                        $display("FAIL %s_sd: sample_data=%h, required %h", r_mon.name, sample_data, r_mon.sd);
                    end
                end
            end

            if (data_ready && !prev_dr) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL strobe_data: got %h, required no sample", sample_data);
                end else begin
                    e = exp_q.pop_front();
                    if (sample_data !== e) begin
                        n_err++;
                        $display("FAIL strobe_data: got %h, required %h", sample_data, e);
                    end
                end
                hi_cnt = 1;
                held   = sample_data;
            end else if (data_ready) begin
                hi_cnt++;
                n_vec++;
                if (sample_data !== held) begin
                    n_err++;
                    $display("FAIL strobe_hold: got %h, required %h", sample_data, held);
                end
            end else if (prev_dr && !reset) begin
                n_vec++;
                if (hi_cnt != STROBE_LEN) begin
                    n_err++;
                    $display("FAIL strobe_len: got %0d cycles, required %0d", hi_cnt, STROBE_LEN);
                end
                if (resp_en) begin
                    mw_resp  = 1'b1;
                    resp_cnt = 2;
                end
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0)
                    mw_resp = 1'b0;
            end
            prev_dr = data_ready;
        end
    end

    initial begin
        bit ok;
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; mw_main = 1'b0; resp_en = 1'b0;
        tick(); tick();
        expect_st("reset_state", 0, 4'b0100, 1, 0, 1, 16'h0000);
        reset = 1'b0;
        tick();

        // Single sample, manual busy pulse.
        push(16'h1234, 1);
        expect_st("s1_push", 1, 4'b0000, 1, 0, 0, '0);
        tick();
        expect_st("s1_pop", 0, 4'b0100, 1, 0, 1, 16'h1234);
        tick();
        expect_st("s1_dr_rise", 0, 4'b0100, 1, 1, 1, 16'h1234);
        tick();
        expect_st("s1_dr_hold", 0, 4'b0100, 1, 1, 1, 16'h1234);
        tick();
        expect_st("s1_dr_fall", 0, 4'b0100, 1, 0, 1, 16'h1234);
        mw_main = 1'b1; tick();
        mw_main = 1'b0; tick();
        expect_st("s1_idle", 0, 4'b0100, 1, 0, 0, '0);

        // Fill while busy, overrun, then a dropped push on the pop edge.
        mw_main = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            push(16'(i), i <= 8);
            if (i == 8)
                expect_st("s2_full", 8, 4'b1000, 1, 0, 0, '0);
        end
        expect_st("s2_overrun", 8, 4'b1010, 1, 0, 0, '0);
        resp_en = 1'b1;
        mw_main = 1'b0;
        push(16'h00AA, 0);
        expect_st("s2_pop_while_full", 7, 4'b0010, 1, 0, 1, 16'h0001);
        drain();
        expect_st("s2_drained", 0, 4'b0110, 1, 0, 0, '0);
        expect_drain("s2_queue");

        // Handshake timeout.
        reset = 1'b1; tick();
        expect_st("s3_reset", 0, 4'b0100, 1, 0, 1, 16'h0000);
        reset = 1'b0; resp_en = 1'b0;
        push(16'hA5A5, 1);
        repeat (4) tick();
        repeat (15) tick();
        expect_st("s3_before_timeout", 0, 4'b0100, 1, 0, 0, '0);
        tick();
        expect_st("s3_timeout", 0, 4'b0101, 1, 0, 0, '0);
        resp_en = 1'b1;
        push(16'h5A5A, 1);
        drain();
        expect_st("s3_next_served", 0, 4'b0101, 1, 0, 0, '0);
        expect_drain("s3_queue");

        // Steady state with push and pop on the same edge, across pointer wrap.
        reset = 1'b1; tick(); reset = 1'b0;
        mw_main = 1'b1;
        push(16'h0100, 1);
        push(16'h0101, 1);
        push(16'h0102, 1);
        expect_st("s4_three", 3, 4'b0000, 1, 0, 0, '0);
        resp_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            if (it > 0) begin
                wait_release(ok);
                if (!ok)
                    note_timeout("s4_release");
            end
            mw_main = 1'b0;
            push(16'h0200 + 16'(it), 1);
            expect_st("s4_push_pop", 3, 4'b0000, 1, 0, 0, '0);
        end
        drain();
        expect_st("s4_drained", 0, 4'b0100, 1, 0, 0, '0);
        expect_drain("s4_queue");

        // Reset in the middle of a strobe.
        reset = 1'b1; tick(); reset = 1'b0;
        resp_en = 1'b0;
        mw_main = 1'b1;
        for (int i = 0; i < 5; i++)
            push(16'h0C00 + 16'(i), i == 0);
        expect_st("s5_five", 5, 4'b0000, 1, 0, 0, '0);
        mw_main = 1'b0;
        tick();
        tick();
        expect_st("s5_strobe", 4, 4'b0000, 1, 1, 1, 16'h0C00);
        reset = 1'b1; wr_en = 1'b1; wr_data = 16'hDEAD;
        tick();
        expect_st("s5_reset", 0, 4'b0100, 1, 0, 1, 16'h0000);
        tick();
        expect_st("s5_reset_wr_ignored", 0, 4'b0100, 1, 0, 1, 16'h0000);
        reset = 1'b0; wr_en = 1'b0;
        tick();
        expect_drain("s5_queue");
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in samples (power of two, >= 2).
REQ-002 Parameter STROBE_LEN, default 2, cycles data_ready stays high per sample (>= 1).
REQ-003 Parameter TIMEOUT, default 16, cycles allowed for downstream modwait to rise after strobe end.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  push request for wr_data this cycle.
REQ-007 wr_data  input  16  sample to enqueue.
REQ-008 modwait  input  1  downstream averager busy indication.
REQ-009 sample_data  output  16  sample presented downstream; held stable for the whole handshake.
REQ-010 data_ready  output  1  strobe telling downstream sample_data is valid.
REQ-011 count  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 overrun  output  1  sticky: a push was dropped because FIFO was full.
REQ-015 hs_err  output  1  sticky: modwait failed to rise within TIMEOUT cycles.

Function
REQ-016 FIFO: DEPTH x 16 circular buffer, wrap-around read/write pointers, occupancy counter; full/empty/count registered and consistent with counter.
REQ-017 Push accepted iff wr_en=1 and count < DEPTH at cycle start; sample visible in count next cycle.
REQ-018 wr_en=1 while full: data discarded, FIFO unchanged, overrun set next cycle; push in same cycle as a pop while full still dropped.
REQ-019 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-020 FSM states: IDLE, STROBE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: if empty=0 and modwait=0, pop head into sample_data, go STROBE; else stay.
REQ-022 STROBE: data_ready=1 for exactly STROBE_LEN consecutive cycles, then WAIT_BUSY with data_ready=0.
REQ-023 WAIT_BUSY: modwait=1 -> WAIT_DONE; TIMEOUT cycles without modwait -> set hs_err, go IDLE.
REQ-024 WAIT_DONE: stay while modwait=1; modwait=0 -> IDLE.
REQ-025 data_ready high only in STROBE; never high in any other state.
REQ-026 sample_data changes only on the IDLE->STROBE pop edge; held otherwise.
REQ-027 Latency: write into empty FIFO at edge k with modwait=0 -> pop at edge k+1, data_ready high from edge k+2 through k+1+STROBE_LEN.
REQ-028 modwait=1 in IDLE blocks pop; no strobe issued until modwait=0.
REQ-029 Back-to-back samples: next pop no earlier than the cycle after return to IDLE; at most one sample outstanding downstream.
REQ-030 modwait rising during STROBE is ignored until WAIT_BUSY, where it is seen immediately if still high.
REQ-031 overrun and hs_err clear only on reset.

Reset
REQ-032 reset=1 at an edge: state IDLE, FIFO emptied (pointers and count 0), sample_data=0, data_ready=0, full=0, empty=1, overrun=0, hs_err=0.
REQ-033 reset mid-handshake: data_ready low from next edge, pending FIFO contents discarded, wr_en ignored while reset=1.

Verification
REQ-034 Single push 0x1234 into empty FIFO, modwait=0 -> sample_data=0x1234, data_ready high 2 cycles starting 2 cycles after push; modwait pulse 1->0 returns FSM to IDLE, empty=1.
REQ-035 Push 9 samples 0x0001..0x0009 with modwait held 1 -> count=8, full=1, overrun=1; after releasing, samples 1..8 emerge in order, 9 never appears.
REQ-036 One strobe, modwait held 0 for 16 cycles -> hs_err=1 at cycle 16 after strobe end, FSM back to IDLE, next sample still served.
REQ-037 Count=3 with simultaneous push and pop -> count stays 3, order preserved across pointer wrap after 20 pushes/pops.
REQ-038 reset asserted during STROBE with count=4 -> next cycle data_ready=0, count=0, empty=1, sample_data=0, flags 0.
